hs32_intc: RTL and testbench

Interrupt controller for the HS32 core: the responder end of the CPU's interrupt interface. It edge-detects 24 request lines into a pending register and selects the highest-priority enabled line. It presents that line's vector and ISR address to the CPU and holds them until the CPU acknowledges. A small memory-mapped slave port lets software program the handler table, the enable mask and the pending bits.

---
 rtl/hs32_intc.sv | 130 +++++++++++++
 tb/tb_hs32_intc.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs32_intc.sv
// hs32_intc: 24-line edge-triggered interrupt controller for the HS32 core.
// Latches the lowest eligible line for the CPU and exposes a small slave port.
module hs32_intc (
  input  logic        i_clk,
  input  logic        reset,
  input  logic [23:0] irq,
  output logic        intrq,
  output logic [4:0]  vec,
  output logic [31:0] handler,
  output logic        nmi,
  input  logic        iack,
  input  logic        s_stb,
  input  logic        s_rw,
  input  logic [4:0]  s_addr,
  input  logic [31:0] s_din,
  output logic [31:0] s_dout,
  output logic        s_ack
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state;
  logic [31:0] tbl [24];
  logic [23:1] enable;
  logic [23:0] pending;
  logic [23:0] prev_irq;
  logic [23:0] rise;
  logic [23:0] eligible;
  logic [23:0] ack_clr;
  logic [23:0] w1c;
  logic [4:0]  sel;
  logic        any;
  logic        wr;
  logic [31:0] rdata;

  assign wr       = s_stb & s_rw;
  assign rise     = irq & ~prev_irq;
  // Line 0 is the NMI: always eligible once pending.
  assign eligible = pending & {enable, 1'b1};
  assign any      = |eligible;
  assign ack_clr  = (state == REQ && iack) ? (24'd1 << vec) : 24'd0;
  assign w1c      = (wr && s_addr == 5'd25) ? s_din[23:0] : 24'd0;

  // Lowest eligible index wins.
  always_comb begin
    sel = 5'd0;
    for (int i = 23; i >= 0; i--) begin
      if (eligible[i]) sel = 5'(i);
    end
  end

  // Slave read data mux.
  always_comb begin
    rdata = 32'd0;
    if (s_addr < 5'd24)
      rdata = tbl[s_addr];
    else if (s_addr == 5'd24)
      rdata = {8'd0, enable, 1'b1};
    else if (s_addr == 5'd25)
      rdata = {8'd0, pending};
  end

  // Edge detect into pending; a new edge beats any clear.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      prev_irq <= '0;
      pending  <= '0;
    end else begin
      prev_irq <= irq;
      pending  <= (pending & ~(ack_clr | w1c)) | rise;
    end
  end

  // Request FSM: latch the winner, hold it frozen until acknowledged.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      intrq   <= 1'b0;
      vec     <= 5'd0;
      handler <= 32'd0;
      nmi     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            vec     <= sel;
            handler <= tbl[sel];
            nmi     <= (sel == 5'd0);
            intrq   <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (iack) begin
            intrq <= 1'b0;
            nmi   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handler table and enable mask writes.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 24; i++) tbl[i] <= '0;
      enable <= '0;
    end else if (wr) begin
      if (s_addr < 5'd24)
        tbl[s_addr] <= s_din;
      else if (s_addr == 5'd24)
        enable <= s_din[23:1];
    end
  end

  // Slave acknowledge and read data, one cycle after the strobe.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      s_ack  <= 1'b0;
      s_dout <= 32'd0;
    end else begin
      s_ack <= s_stb;
      if (s_stb && !s_rw)
        s_dout <= rdata;
    end
  end

endmodule

// File: tb/tb_hs32_intc.sv
// tb_hs32_intc: register table vectors, directed request sequences,
// and randomized traffic against a behavioural model.
module tb_hs32_intc;

  logic        i_clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] irq = '0;
  logic        iack = 1'b0;
  logic        s_stb = 1'b0;
  logic        s_rw = 1'b0;
  logic [4:0]  s_addr = '0;
  logic [31:0] s_din = '0;
  logic        intrq;
  logic [4:0]  vec;
  logic [31:0] handler;
  logic        nmi;
  logic [31:0] s_dout;
  logic        s_ack;

  int checks = 0;
  int failures = 0;

  hs32_intc dut (
    .i_clk(i_clk), .reset(reset), .irq(irq),
    .intrq(intrq), .vec(vec), .handler(handler), .nmi(nmi),
    .iack(iack), .s_stb(s_stb), .s_rw(s_rw), .s_addr(s_addr),
    .s_din(s_din), .s_dout(s_dout), .s_ack(s_ack)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rw;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] exp;
  } tv_t;

  tv_t tv[12];

  // behavioural model state
  bit          m_pend [24];
  bit          m_en   [24];
  bit          m_prev [24];
  logic [31:0] m_tbl  [24];
  bit          m_busy;
  int          m_vec;
  logic [31:0] m_handler;
  bit          m_ack;
  bit   [23:0] m_clr;
  int          m_win;
  logic [23:0] flip;
  logic [31:0] rd;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    s_stb = 1'b1; s_rw = 1'b1; s_addr = a; s_din = d;
    step(1);
    s_stb = 1'b0; s_rw = 1'b0;
    check("wr_ack", 32'(s_ack), 32'd1);
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
    s_stb = 1'b1; s_rw = 1'b0; s_addr = a;
    step(1);
    s_stb = 1'b0;
    check("rd_ack", 32'(s_ack), 32'd1);
    d = s_dout;
  endtask

  initial begin
    tv[0]  = '{1'b1, 5'd3,  32'hDEADBEEF, 32'h0};
    tv[1]  = '{1'b0, 5'd3,  32'h0,        32'hDEADBEEF};
    tv[2]  = '{1'b1, 5'd23, 32'h12345678, 32'h0};
    tv[3]  = '{1'b0, 5'd23, 32'h0,        32'h12345678};
    tv[4]  = '{1'b1, 5'd24, 32'hFFFFFFFF, 32'h0};
    tv[5]  = '{1'b0, 5'd24, 32'h0,        32'h00FFFFFF};
    tv[6]  = '{1'b1, 5'd24, 32'h0,        32'h0};
    tv[7]  = '{1'b0, 5'd24, 32'h0,        32'h00000001};
    tv[8]  = '{1'b0, 5'd31, 32'h0,        32'h0};
    tv[9]  = '{1'b1, 5'd28, 32'h0000AAAA, 32'h0};
    tv[10] = '{1'b0, 5'd28, 32'h0,        32'h0};
    tv[11] = '{1'b0, 5'd25, 32'h0,        32'h0};

    // reset state
    step(3);
    check("rst_intrq", 32'(intrq), 0);
    check("rst_vec", 32'(vec), 0);
    check("rst_handler", handler, 0);
    check("rst_nmi", 32'(nmi), 0);
    check("rst_ack", 32'(s_ack), 0);
    check("rst_dout", s_dout, 0);
    reset = 1'b0;
    step(1);
    check("post_rst_intrq", 32'(intrq), 0);

    // register table
    for (int i = 0; i < 12; i++) begin
      if (tv[i].rw) begin
        bus_wr(tv[i].addr, tv[i].din);
      end else begin
        bus_rd(tv[i].addr, rd);
        check($sformatf("reg_rd[%0d]", i), rd, tv[i].exp);
      end
    end
    step(1);
    check("ack_one_cycle", 32'(s_ack), 0);

    // masked line still pends
    irq = 24'h000020;
    step(1);
    irq = '0;
    step(2);
    check("masked_intrq", 32'(intrq), 0);
    bus_rd(5'd25, rd);
    check("masked_pending", rd, 32'h20);
    bus_wr(5'd25, 32'hFFFFFF);
    bus_rd(5'd25, rd);
    check("w1c_pending", rd, 32'h0);

    // basic request
    bus_wr(5'd5, 32'h00001000);
    bus_wr(5'd24, 32'h20);
    irq = 24'h000020;
    step(1);
    irq = '0;
    check("basic_not_yet", 32'(intrq), 0);
    step(1);
    check("basic_intrq", 32'(intrq), 1);
    check("basic_vec", 32'(vec), 5);
    check("basic_handler", handler, 32'h1000);
    check("basic_nmi", 32'(nmi), 0);
    iack = 1'b1;
    step(1);
    iack = 1'b0;
    check("basic_ack_drop", 32'(intrq), 0);
    bus_rd(5'd25, rd);
    check("basic_pend_clr", rd, 32'h0);

    // priority
    bus_wr(5'd24, 32'hFFFFFE);
    irq = 24'h000208;
    step(1);
    irq = '0;
    step(1);
    check("prio_intrq", 32'(intrq), 1);
    check("prio_vec_first", 32'(vec), 3);
    iack = 1'b1;
    step(1);
    iack = 1'b0;
    check("prio_gap", 32'(intrq), 0);
    step(1);
    check("prio_intrq2", 32'(intrq), 1);
    check("prio_vec_second", 32'(vec), 9);
    iack = 1'b1;
    step(1);
    iack = 1'b0;

    // NMI ignores enable
    bus_wr(5'd24, 32'h0);
    bus_wr(5'd0, 32'hFFFF0000);
    irq = 24'h000001;
    step(1);
    irq = '0;
    step(1);
    check("nmi_intrq", 32'(intrq), 1);
    check("nmi_flag", 32'(nmi), 1);
    check("nmi_vec", 32'(vec), 0);
    check("nmi_handler", handler, 32'hFFFF0000);
    iack = 1'b1;
    step(1);
    iack = 1'b0;
    check("nmi_flag_drop", 32'(nmi), 0);

    // request stability
    bus_wr(5'd24, 32'h80);
    bus_wr(5'd7, 32'h00007777);
    irq = 24'h000080;
    step(1);
    irq = '0;
    step(1);
    check("stab_intrq", 32'(intrq), 1);
    bus_wr(5'd24, 32'h0);
    bus_wr(5'd25, 32'h80);
    bus_wr(5'd7, 32'h0);
    check("stab_intrq_held", 32'(intrq), 1);
    check("stab_vec", 32'(vec), 7);
    check("stab_handler", handler, 32'h7777);
    iack = 1'b1;
    step(1);
    iack = 1'b0;
    step(2);
    check("stab_no_rereq", 32'(intrq), 0);

    // new edge beats iack clear
    bus_wr(5'd24, 32'h80);
    irq = 24'h000080;
    step(1);
    irq = '0;
    step(1);
    check("sw_intrq", 32'(intrq), 1);
    iack = 1'b1;
    irq = 24'h000080;
    step(1);
    iack = 1'b0;
    irq = '0;
    check("sw_gap", 32'(intrq), 0);
    step(1);
    check("sw_rereq", 32'(intrq), 1);
    check("sw_vec", 32'(vec), 7);
    iack = 1'b1;
    step(1);
    iack = 1'b0;
    step(1);
    check("sw_idle", 32'(intrq), 0);

    // back-to-back strobes
    s_stb = 1'b1; s_rw = 1'b0; s_addr = 5'd24;
    step(1);
    check("b2b_ack1", 32'(s_ack), 1);
    check("b2b_dout1", s_dout, 32'h81);
    s_addr = 5'd31;
    step(1);
    s_stb = 1'b0;
    check("b2b_ack2", 32'(s_ack), 1);
    check("b2b_dout2", s_dout, 32'h0);
    step(1);
    check("b2b_ack_end", 32'(s_ack), 0);
    check("b2b_dout_hold", s_dout, 32'h0);

    // asynchronous reset mid-request
    irq = 24'h000001;
    step(1);
    irq = '0;
    step(1);
    check("ar_intrq", 32'(intrq), 1);
    #2 reset = 1'b1;
    #1;
    check("ar_async_drop", 32'(intrq), 0);
    check("ar_nmi_drop", 32'(nmi), 0);
    step(1);
    reset = 1'b0;
    step(1);
    bus_rd(5'd24, rd);
    check("ar_enable_lost", rd, 32'h1);
    bus_rd(5'd0, rd);
    check("ar_table_lost", rd, 32'h0);

    // randomized traffic vs model
    for (int n = 0; n < 24; n++) begin
      m_pend[n] = 0; m_en[n] = 0; m_prev[n] = 0; m_tbl[n] = '0;
    end
    m_busy = 0; m_vec = 0; m_handler = '0; m_ack = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 24; n++) flip[n] = ($urandom_range(7) == 0);
      irq = irq ^ flip;
      iack = ($urandom_range(2) == 0);
      s_stb = ($urandom_range(4) == 0);
      s_rw = s_stb;
      s_din = $urandom;
      case ($urandom_range(3))
        0: s_addr = 5'($urandom_range(23));
        1: s_addr = 5'd24;
        2: s_addr = 5'd25;
        default: s_addr = 5'($urandom_range(31, 26));
      endcase
      @(posedge i_clk);
      m_win = -1;
      for (int n = 23; n >= 0; n--)
        if (m_pend[n] && (m_en[n] || n == 0)) m_win = n;
      m_clr = '0;
      if (!m_busy) begin
        if (m_win >= 0) begin
          m_busy = 1;
          m_vec = m_win;
          m_handler = m_tbl[m_win];
        end
      end else if (iack) begin
        m_busy = 0;
        m_clr[m_vec] = 1'b1;
      end
      if (s_stb && s_rw && s_addr == 5'd25) m_clr = m_clr | s_din[23:0];
      for (int n = 0; n < 24; n++) begin
        if (irq[n] && !m_prev[n]) m_pend[n] = 1;
        else if (m_clr[n]) m_pend[n] = 0;
        m_prev[n] = irq[n];
      end
      if (s_stb && s_rw) begin
        if (s_addr < 5'd24) m_tbl[s_addr] = s_din;
        else if (s_addr == 5'd24)
          for (int n = 0; n < 24; n++) m_en[n] = s_din[n];
      end
      m_ack = s_stb;
      #1;
      check("rnd_intrq", 32'(intrq), 32'(m_busy));
      check("rnd_ack", 32'(s_ack), 32'(m_ack));
      if (m_busy) begin
        check("rnd_vec", 32'(vec), 32'(m_vec));
        check("rnd_handler", handler, m_handler);
        check("rnd_nmi", 32'(nmi), 32'(m_vec == 0));
      end else begin
        check("rnd_nmi_idle", 32'(nmi), 0);
      end
    end
    s_stb = 1'b0; s_rw = 1'b0; iack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
